pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_fetch_stage.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_stage.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_stage.sv
// Single-outstanding instruction fetch stage with exception redirect.
// Optional PC_ALIGN_CHECK_EN: misaligned pc raises if_adel instead of fetching.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | just out of reset, first cycle; stray responses ignored
// S_REQ  | imem_req asserted with imem_addr = pc, waiting for addr_ok
// S_WAIT | request accepted, waiting for data_ok
// S_DROP | request accepted but flushed, swallow its response
// S_HOLD | if_pc/if_instr valid, waiting for decode to take it
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        exp_flush,
    input  logic [31:0] exception_new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_addr_ok,
    input  logic        imem_data_ok,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         pc_misaligned;
    logic         req_accept;

`ifdef PC_ALIGN_CHECK_EN
    logic if_adel_q, if_adel_d;
    assign pc_misaligned = (pc_q[1:0] != 2'b00);
    assign imem_addr     = pc_q;
    assign if_adel       = if_adel_q;
`else
    assign pc_misaligned = 1'b0;
    assign imem_addr     = {pc_q[31:2], 2'b00};
    assign if_adel       = 1'b0;
`endif

    assign imem_req   = (state_q == S_REQ) && !pc_misaligned;
    assign req_accept = imem_req && imem_addr_ok;
    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign if_instr   = if_instr_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
`ifdef PC_ALIGN_CHECK_EN
        if_adel_d  = if_adel_q;
`endif

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (pc_misaligned) begin
                    state_d    = S_HOLD;
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = NOP_INSTR;
`ifdef PC_ALIGN_CHECK_EN
                    if_adel_d  = 1'b1;
`endif
                end else if (req_accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_data_ok) begin
                    state_d    = S_HOLD;
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem_rdata;
`ifdef PC_ALIGN_CHECK_EN
                    if_adel_d  = 1'b0;
`endif
                end
            end
            S_DROP: begin
                if (imem_data_ok) state_d = S_REQ;
            end
            S_HOLD: begin
                if (id_ready) begin
                    state_d    = S_REQ;
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything; an accepted-but-unanswered request
        // must still have its response swallowed in S_DROP.
        if (exp_flush) begin
            pc_d       = exception_new_pc;
            if_valid_d = 1'b0;
            if_pc_d    = if_pc_q;
            if_instr_d = if_instr_q;
`ifdef PC_ALIGN_CHECK_EN
            if_adel_d  = if_adel_q;
`endif
            case (state_q)
                S_REQ:   state_d = req_accept ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_data_ok ? S_REQ : S_DROP;
                S_DROP:  state_d = imem_data_ok ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= NOP_INSTR;
`ifdef PC_ALIGN_CHECK_EN
            if_adel_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
`ifdef PC_ALIGN_CHECK_EN
            if_adel_q  <= if_adel_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage; honours PC_ALIGN_CHECK_EN like the RTL.
module tb_pc_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_out_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        exp_flush;
    logic [31:0] exception_new_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_addr_ok;
    logic        imem_data_ok;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_adel;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 0;

    logic [31:0] exp_addr_q[$];
    exp_out_t    exp_out_q[$];

    pc_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .next_pc          (next_pc),
        .exp_flush        (exp_flush),
        .exception_new_pc (exception_new_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_addr_ok     (imem_addr_ok),
        .imem_data_ok     (imem_data_ok),
        .imem_rdata       (imem_rdata),
        .if_valid         (if_valid),
        .id_ready         (id_ready),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .if_adel          (if_adel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h9BC8_0001;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a, input bit deliver);
        exp_out_t e;
        exp_addr_q.push_back(a);
        if (deliver) begin
            e.pc = a; e.instr = mem_word(a); e.adel = 1'b0;
            exp_out_q.push_back(e);
        end
    endtask

    // Called in HOLD: hand the instruction to decode and redirect to a.
    task automatic accept(input logic [31:0] a, input bit deliver);
        next_pc  = a;
        id_ready = 1'b1;
        push_fetch(a, deliver);
        @(negedge clk);
        id_ready = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        int k = 0;
        while (!if_valid && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (!if_valid) check_eq("wait_valid_timeout", 32'(if_valid), 32'd1);
    endtask

    // Memory model: one response per accepted request, lat cycles after WAIT entry.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] pend_addr;
        pend = 1'b0; cnt = 0; pend_addr = '0;
        imem_data_ok = 1'b0;
        imem_rdata   = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_data_ok = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_data_ok = 1'b1;
                    imem_rdata   = mem_word(pend_addr);
                    pend         = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (imem_req && imem_addr_ok) begin
                if (exp_addr_q.size() == 0)
                    check_eq("unexpected_req", 32'(exp_addr_q.size()), 32'd1);
                else
                    check_eq("imem_addr", imem_addr, exp_addr_q.pop_front());
                pend      = 1'b1;
                cnt       = lat;
                pend_addr = imem_addr;
            end
        end
    end

    // Output monitor: every rise of if_valid must match the next expected fetch.
    initial begin
        logic     prev_v;
        exp_out_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (if_valid && !prev_v) begin
                if (exp_out_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'(exp_out_q.size()), 32'd1);
                end else begin
                    e = exp_out_q.pop_front();
                    check_eq("if_pc", if_pc, e.pc);
                    check_eq("if_instr", if_instr, e.instr);
                    check_eq("if_adel", 32'(if_adel), 32'(e.adel));
                end
            end
            prev_v = if_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int tprev;
        int t;
        tprev = 0;
        reset = 1'b1; next_pc = '0; exp_flush = 1'b0; exception_new_pc = '0;
        imem_addr_ok = 1'b1; id_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_if_instr", if_instr, 32'h0);
        check_eq("rst_if_adel", 32'(if_adel), 32'd0);

        // first fetch from RESET_PC, zero-wait memory
        lat = 0;
        push_fetch(RST_PC, 1'b1);
        reset = 1'b0;
        wait_valid(20);
        repeat (5) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(if_valid), 32'd1);
            check_eq("hold_pc", if_pc, 32'hBFC0_0000);
            check_eq("hold_instr", if_instr, 32'h2408_0001);
        end
        accept(32'hBFC0_0004, 1'b1);
        wait_valid(20);

        // flush in WAIT, response two cycles later goes to DROP
        lat = 2;
        accept(32'hBFC0_0008, 1'b0);
        @(negedge clk);
        exp_flush = 1'b1; exception_new_pc = 32'hBFC0_0380;
        push_fetch(32'hBFC0_0380, 1'b1);
        @(negedge clk);
        exp_flush = 1'b0;
        check_eq("drop_if_valid", 32'(if_valid), 32'd0);
        check_eq("drop_imem_req", 32'(imem_req), 32'd0);
        wait_valid(30);

        // flush in WAIT with data_ok in the same cycle
        lat = 0;
        accept(32'hBFC0_000C, 1'b0);
        @(negedge clk);
        exp_flush = 1'b1; exception_new_pc = 32'hBFC0_0400;
        push_fetch(32'hBFC0_0400, 1'b1);
        @(negedge clk);
        exp_flush = 1'b0;
        check_eq("flush_data_if_valid", 32'(if_valid), 32'd0);
        check_eq("flush_data_req", 32'(imem_req), 32'd1);
        wait_valid(20);

        // flush in REQ coincident with addr_ok
        lat = 1;
        accept(32'hBFC0_0410, 1'b0);
        exp_flush = 1'b1; exception_new_pc = 32'hBFC0_0500;
        push_fetch(32'hBFC0_0500, 1'b1);
        @(negedge clk);
        exp_flush = 1'b0;
        check_eq("req_flush_if_valid", 32'(if_valid), 32'd0);
        check_eq("req_flush_imem_req", 32'(imem_req), 32'd0);
        wait_valid(20);

        // flush together with id_ready in HOLD
        lat = 0;
        next_pc = 32'h8000_0010; id_ready = 1'b1;
        exp_flush = 1'b1; exception_new_pc = 32'hBFC0_0380;
        push_fetch(32'hBFC0_0380, 1'b1);
        @(negedge clk);
        id_ready = 1'b0; exp_flush = 1'b0;
        wait_valid(20);

        // addr_ok stalled: address held, then a flush retargets the request
        imem_addr_ok = 1'b0;
        next_pc = 32'hBFC0_0384; id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        repeat (3) begin
            check_eq("stall_req", 32'(imem_req), 32'd1);
            check_eq("stall_addr", imem_addr, 32'hBFC0_0384);
            @(negedge clk);
        end
        exp_flush = 1'b1; exception_new_pc = 32'hBFC0_0600;
        push_fetch(32'hBFC0_0600, 1'b1);
        @(negedge clk);
        exp_flush = 1'b0;
        imem_addr_ok = 1'b1;
        wait_valid(20);

        // misaligned next_pc
`ifdef PC_ALIGN_CHECK_EN
        begin
            exp_out_t e;
            e.pc = 32'hBFC0_0006; e.instr = 32'h0; e.adel = 1'b1;
            exp_out_q.push_back(e);
            next_pc = 32'hBFC0_0006; id_ready = 1'b1;
            @(negedge clk);
            id_ready = 1'b0;
            check_eq("misalign_no_req", 32'(imem_req), 32'd0);
            wait_valid(20);
            check_eq("misalign_adel", 32'(if_adel), 32'd1);
        end
`else
        begin
            exp_out_t e;
            exp_addr_q.push_back(32'hBFC0_0004);
            e.pc = 32'hBFC0_0006; e.instr = mem_word(32'hBFC0_0004); e.adel = 1'b0;
            exp_out_q.push_back(e);
            next_pc = 32'hBFC0_0006; id_ready = 1'b1;
            @(negedge clk);
            id_ready = 1'b0;
            check_eq("misalign_req", 32'(imem_req), 32'd1);
            wait_valid(20);
            check_eq("misalign_adel", 32'(if_adel), 32'd0);
        end
`endif
        accept(32'hBFC0_0700, 1'b1);
        wait_valid(20);

        // best-case throughput: one instruction every 3 cycles
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_valid(20);
            t = cyc;
            if (i > 0) check_eq("throughput", 32'(t - tprev), 32'd3);
            tprev = t;
            accept(32'hBFC0_0800 + 32'(4 * i), 1'b1);
        end
        wait_valid(20);

        // reset asserted in WAIT
        lat = 1;
        accept(32'hBFC0_0900, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_wait_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_wait_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_wait_if_pc", if_pc, 32'h0);
        push_fetch(RST_PC, 1'b1);
        reset = 1'b0;
        wait_valid(20);

        repeat (5) @(negedge clk);
        check_eq("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        check_eq("out_queue_empty", 32'(exp_out_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
